// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hc_state_e : sequencer state (RUN, MDU_BUSY)
//   RegIdxW    : register-index width of the five-stage core
package hazard_controller_pkg;

    localparam int unsigned RegIdxW = 5;

    typedef enum logic [0:0] {
        StRun     = 1'b0,
        StMduBusy = 1'b1
    } hc_state_e;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk     : clock
//   rst     : synchronous active-high reset, counter to zero
//   inc_i   : increment this cycle (ignored once at all ones)
//   clr_i   : clear to zero this cycle (wins over inc_i)
//   count_o : current count
module hazard_controller_sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer for the five-stage core. Resolves load-use, multi-cycle
// MDU, data-memory wait and EX-redirect hazards by driving per-stage stall/flush strobes.
//   fd_*           : D-stage source operands
//   de_*           : E-stage instruction info (load, writeback, rd, MDU op)
//   mdu_done       : MDU result valid, held until mdu_ack
//   ex_redirect    : taken branch/jump resolved in E
//   mem_req/dmem_ready : M-stage data-memory handshake
//   stall_*/flush_*: per-stage hold / bubble strobes (combinational)
//   mdu_start/ack  : single-cycle MDU launch / consume pulses
//   mem_fault      : sticky data-memory timeout flag
//   stall_count    : saturating count of stall_f cycles
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RegIdxW-1:0]     fd_rs1,
    input  logic [RegIdxW-1:0]     fd_rs2,
    input  logic                   fd_uses_rs1,
    input  logic                   fd_uses_rs2,
    input  logic                   de_mem_read,
    input  logic                   de_regfile_we,
    input  logic [RegIdxW-1:0]     de_rd,
    input  logic                   de_mdu_op,
    input  logic                   mdu_done,
    input  logic                   ex_redirect,
    input  logic                   mem_req,
    input  logic                   dmem_ready,
    output logic                   stall_f,
    output logic                   stall_d,
    output logic                   stall_e,
    output logic                   stall_m,
    output logic                   flush_d,
    output logic                   flush_e,
    output logic                   flush_m,
    output logic                   flush_w,
    output logic                   mdu_start,
    output logic                   mdu_ack,
    output logic                   mem_fault,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // Wide enough to reach MEM_TIMEOUT; at least one bit when the timeout is disabled.
    localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    hc_state_e        state_q;
    logic             mem_fault_q;
    logic             mem_stall;
    logic             mdu_stall;
    logic             load_use;
    logic             fault_set;
    logic [WaitW-1:0] wait_cnt;
    logic [STALL_CNT_W-1:0] stall_cnt;

    assign mem_stall = mem_req && !dmem_ready;

    assign mdu_stall = ((state_q == StRun) && de_mdu_op) ||
                       ((state_q == StMduBusy) && !mdu_done);

    assign load_use = de_mem_read && de_regfile_we && (de_rd != '0) &&
                      ((fd_uses_rs1 && (de_rd == fd_rs1)) ||
                       (fd_uses_rs2 && (de_rd == fd_rs2)));

    // Priority encoder: only the highest active hazard drives the strobes.
    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        flush_w   = 1'b0;
        mdu_start = 1'b0;
        mdu_ack   = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (mdu_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (ex_redirect) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
            // A memory stall freezes the MDU handshake so the result is not lost.
            mdu_start = (state_q == StRun) && de_mdu_op && !mem_stall;
            mdu_ack   = (state_q == StMduBusy) && mdu_done && !mem_stall;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            case (state_q)
                StRun:     if (mdu_start) state_q <= StMduBusy;
                StMduBusy: if (mdu_ack)   state_q <= StRun;
            endcase
        end
    end

    // Fires on the edge that completes the MEM_TIMEOUT-th consecutive wait cycle.
    assign fault_set = (MEM_TIMEOUT != 0) && mem_stall &&
                       ((32'(wait_cnt) + 32'd1) == MEM_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_fault_q <= 1'b0;
        end else if (fault_set) begin
            mem_fault_q <= 1'b1;
        end
    end

    hazard_controller_sat_counter #(
        .Width (WaitW)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (mem_stall),
        .clr_i   (!mem_stall),
        .count_o (wait_cnt)
    );

    hazard_controller_sat_counter #(
        .Width (STALL_CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_f),
        .clr_i   (1'b0),
        .count_o (stall_cnt)
    );

    // Registered outputs are forced low while reset is held.
    assign mem_fault   = mem_fault_q && !rst;
    assign stall_count = rst ? '0 : stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] fd_rs1, fd_rs2, de_rd;
    logic       fd_uses_rs1, fd_uses_rs2, de_mem_read, de_regfile_we, de_mdu_op;
    logic       mdu_done, ex_redirect, mem_req, dmem_ready;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_m, flush_w;
    logic       mdu_start, mdu_ack, mem_fault;
    logic [3:0] stall_count;
    logic [9:0] strobes;

    int checks   = 0;
    int failures = 0;

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, mdu_start, mdu_ack}
    localparam logic [9:0] VNone   = 10'b0000000000;
    localparam logic [9:0] VMem    = 10'b1111000100;
    localparam logic [9:0] VMdu    = 10'b1110001000;
    localparam logic [9:0] VLaunch = 10'b1110001010;
    localparam logic [9:0] VAck    = 10'b0000000001;
    localparam logic [9:0] VRedir  = 10'b0000110000;
    localparam logic [9:0] VLu     = 10'b1100010000;

    always #5 clk = ~clk;

    assign strobes = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
                      flush_m, flush_w, mdu_start, mdu_ack};

    hazard_controller #(
        .STALL_CNT_W (4),
        .MEM_TIMEOUT (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fd_rs1        (fd_rs1),
        .fd_rs2        (fd_rs2),
        .fd_uses_rs1   (fd_uses_rs1),
        .fd_uses_rs2   (fd_uses_rs2),
        .de_mem_read   (de_mem_read),
        .de_regfile_we (de_regfile_we),
        .de_rd         (de_rd),
        .de_mdu_op     (de_mdu_op),
        .mdu_done      (mdu_done),
        .ex_redirect   (ex_redirect),
        .mem_req       (mem_req),
        .dmem_ready    (dmem_ready),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .stall_e       (stall_e),
        .stall_m       (stall_m),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .flush_m       (flush_m),
        .flush_w       (flush_w),
        .mdu_start     (mdu_start),
        .mdu_ack       (mdu_ack),
        .mem_fault     (mem_fault),
        .stall_count   (stall_count)
    );

    task automatic clear_inputs();
        fd_rs1 = 5'd0; fd_rs2 = 5'd0; de_rd = 5'd0;
        fd_uses_rs1 = 1'b0; fd_uses_rs2 = 1'b0;
        de_mem_read = 1'b0; de_regfile_we = 1'b0; de_mdu_op = 1'b0;
        mdu_done = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Load x5 in E, D reads x5 and x1.
    task automatic set_load_use(input logic [4:0] rd);
        de_mem_read = 1'b1; de_regfile_we = 1'b1; de_rd = rd;
        fd_rs1 = 5'd5; fd_rs2 = 5'd1; fd_uses_rs1 = 1'b1; fd_uses_rs2 = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        mem_req = 1'b1; dmem_ready = 1'b0; de_mdu_op = 1'b1; ex_redirect = 1'b1;
        #1;
        checks++;
        if (strobes !== VNone) begin
            failures++; $display("FAIL reset_strobes: got %b want %b", strobes, VNone);
        end
        tick();
        tick();
        checks++;
        if (stall_count !== 4'd0 || mem_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: count=%0d fault=%b want 0/0", stall_count, mem_fault);
        end
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (strobes !== VNone) begin
            failures++; $display("FAIL reset_idle: got %b want %b", strobes, VNone);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5'd5);
        #1;
        checks++;
        if (strobes !== VLu) begin
            failures++; $display("FAIL lu_rs1: got %b want %b", strobes, VLu);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (strobes !== VNone || stall_count !== 4'd1) begin
            failures++;
            $display("FAIL lu_release: got %b cnt=%0d want %b cnt=1", strobes, stall_count, VNone);
        end
        set_load_use(5'd1);
        #1;
        checks++;
        if (strobes !== VLu) begin
            failures++; $display("FAIL lu_rs2: got %b want %b", strobes, VLu);
        end
        set_load_use(5'd0);
        fd_rs1 = 5'd0;
        #1;
        checks++;
        if (strobes !== VNone) begin
            failures++; $display("FAIL lu_x0: got %b want %b", strobes, VNone);
        end
        set_load_use(5'd5);
        fd_uses_rs1 = 1'b0;
        #1;
        checks++;
        if (strobes !== VNone) begin
            failures++; $display("FAIL lu_unused_src: got %b want %b", strobes, VNone);
        end
        set_load_use(5'd5);
        de_regfile_we = 1'b0;
        #1;
        checks++;
        if (strobes !== VNone) begin
            failures++; $display("FAIL lu_no_we: got %b want %b", strobes, VNone);
        end
        clear_inputs();
    endtask

    task automatic test_mdu();
        do_reset();
        de_mdu_op = 1'b1;
        #1;
        checks++;
        if (strobes !== VLaunch) begin
            failures++; $display("FAIL mdu_launch: got %b want %b", strobes, VLaunch);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            ex_redirect = (i == 1);
            #1;
            checks++;
            if (strobes !== VMdu) begin
                failures++; $display("FAIL mdu_busy%0d: got %b want %b", i, strobes, VMdu);
            end
        end
        tick();
        ex_redirect = 1'b0;
        mdu_done = 1'b1;
        #1;
        checks++;
        if (strobes !== VAck) begin
            failures++; $display("FAIL mdu_ack: got %b want %b", strobes, VAck);
        end
        tick();
        mdu_done = 1'b0;
        #1;
        checks++;
        if (strobes !== VLaunch || stall_count !== 4'd5) begin
            failures++;
            $display("FAIL mdu_b2b: got %b cnt=%0d want %b cnt=5", strobes, stall_count, VLaunch);
        end
        tick();
        mdu_done = 1'b1;
        #1;
        checks++;
        if (strobes !== VAck || stall_count !== 4'd6) begin
            failures++;
            $display("FAIL mdu_b2b_ack: got %b cnt=%0d want %b cnt=6", strobes, stall_count, VAck);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (strobes !== VNone) begin
            failures++; $display("FAIL mdu_idle: got %b want %b", strobes, VNone);
        end
    endtask

    task automatic test_mdu_mem_stall();
        do_reset();
        de_mdu_op = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0;
        #1;
        checks++;
        if (strobes !== VMem) begin
            failures++; $display("FAIL mdu_launch_memstall: got %b want %b", strobes, VMem);
        end
        tick();
        mem_req = 1'b0;
        #1;
        checks++;
        if (strobes !== VLaunch) begin
            failures++; $display("FAIL mdu_late_launch: got %b want %b", strobes, VLaunch);
        end
        tick();
        mdu_done = 1'b1; mem_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (strobes !== VMem) begin
                failures++; $display("FAIL mdu_done_memstall%0d: got %b want %b", i, strobes, VMem);
            end
            tick();
        end
        mem_req = 1'b0;
        #1;
        checks++;
        if (strobes !== VAck) begin
            failures++; $display("FAIL mdu_ack_after_mem: got %b want %b", strobes, VAck);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (strobes !== VNone || mem_fault !== 1'b0) begin
            failures++;
            $display("FAIL mdu_mem_end: got %b fault=%b want %b fault=0", strobes, mem_fault, VNone);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        set_load_use(5'd5);
        ex_redirect = 1'b1;
        #1;
        checks++;
        if (strobes !== VRedir) begin
            failures++; $display("FAIL redir_over_lu: got %b want %b", strobes, VRedir);
        end
        mem_req = 1'b1; dmem_ready = 1'b0;
        #1;
        checks++;
        if (strobes !== VMem) begin
            failures++; $display("FAIL memstall_over_redir: got %b want %b", strobes, VMem);
        end
        clear_inputs();
        ex_redirect = 1'b1;
        #1;
        checks++;
        if (strobes !== VRedir) begin
            failures++; $display("FAIL redir_alone: got %b want %b", strobes, VRedir);
        end
        clear_inputs();
    endtask

    task automatic test_mem_timeout();
        do_reset();
        // Two short waits separated by a ready cycle must not accumulate.
        for (int i = 0; i < 5; i++) begin
            mem_req = 1'b1;
            dmem_ready = (i == 2);
            tick();
        end
        clear_inputs();
        tick();
        checks++;
        if (mem_fault !== 1'b0) begin
            failures++; $display("FAIL timeout_nonconsec: got %b want 0", mem_fault);
        end
        mem_req = 1'b1; dmem_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (mem_fault !== 1'b0) begin
            failures++; $display("FAIL timeout_early: got %b want 0", mem_fault);
        end
        tick();
        checks++;
        if (mem_fault !== 1'b1) begin
            failures++; $display("FAIL timeout_set: got %b want 1", mem_fault);
        end
        tick();
        #1;
        checks++;
        if (strobes !== VMem) begin
            failures++; $display("FAIL timeout_still_stalls: got %b want %b", strobes, VMem);
        end
        tick();
        dmem_ready = 1'b1;
        tick();
        checks++;
        if (mem_fault !== 1'b1 || strobes !== VNone) begin
            failures++;
            $display("FAIL timeout_sticky: fault=%b strobes=%b want 1/%b", mem_fault, strobes, VNone);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_fault !== 1'b0) begin
            failures++; $display("FAIL timeout_rst_gate: got %b want 0", mem_fault);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (mem_fault !== 1'b0) begin
            failures++; $display("FAIL timeout_cleared: got %b want 0", mem_fault);
        end
        clear_inputs();
    endtask

    task automatic test_stall_saturation();
        do_reset();
        set_load_use(5'd5);
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (stall_count !== 4'd15) begin
            failures++; $display("FAIL sat_reach: got %0d want 15", stall_count);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stall_count !== 4'd15) begin
            failures++; $display("FAIL sat_hold: got %0d want 15", stall_count);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_mdu();
        test_mdu_mem_stall();
        test_redirect();
        test_mem_timeout();
        test_stall_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
